// File: rtl/common_fifo_d16.sv
// 16-entry first-word-fall-through FIFO with registered occupancy count.
// Define COMMON_FIFO_D16_ERR_EN to add the sticky o_err protocol-error flag.
module common_fifo_d16 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_wready,
    input  logic             i_ren,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rvalid,
`ifdef COMMON_FIFO_D16_ERR_EN
    output logic [4:0]       o_count,
    output logic             o_err
`else
    output logic [4:0]       o_count
`endif
);

    logic [WIDTH-1:0] r_mem [16];
    logic [3:0]       r_wptr;
    logic [3:0]       r_rptr;
    logic [4:0]       r_count;

    logic             w_wr;
    logic             w_rd;
    logic             w_dec;
    logic             w_upd;
    logic             w_carry;
    logic [4:0]       w_cnt_nxt;

    assign o_wready = (r_count != 5'd16);
    assign o_rvalid = (r_count != 5'd0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rptr];

    assign w_wr  = i_wen & o_wready;
    assign w_rd  = i_ren & o_rvalid;
    assign w_dec = w_rd & ~w_wr;
    assign w_upd = w_wr ^ w_rd;

    // Shared inc/dec; carry out is a borrow on decrement, overflow on increment
    always_comb begin
        {w_carry, w_cnt_nxt} = 6'd0;
        if (w_dec) begin
            {w_carry, w_cnt_nxt} = {1'b0, r_count} - 6'd1;
        end else begin
            {w_carry, w_cnt_nxt} = {1'b0, r_count} + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= 4'd0;
            r_rptr  <= 4'd0;
            r_count <= 5'd0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 4'd1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 4'd1;
            end
            if (w_upd) begin
                r_count <= w_cnt_nxt;
            end
            assert (!(w_upd && w_carry))
                else $error("fifo count inc/dec carry");
        end
    end

`ifdef COMMON_FIFO_D16_ERR_EN
    logic r_err;

    assign o_err = r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if ((i_wen & ~o_wready) | (i_ren & ~o_rvalid)) begin
            r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_common_fifo_d16.sv
// Directed self-checking bench for common_fifo_d16.
// Covers reset, FWFT latency, full/empty boundaries, wrap and async reset.
module tb_common_fifo_d16;

    logic       clk;
    logic       resetn;
    logic       i_wen;
    logic [7:0] i_wdata;
    logic       o_wready;
    logic       i_ren;
    logic [7:0] o_rdata;
    logic       o_rvalid;
    logic [4:0] o_count;
`ifdef COMMON_FIFO_D16_ERR_EN
    logic       o_err;
`endif

    int n_chk;
    int n_fail;

    common_fifo_d16 #(.WIDTH(8)) u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .i_wen    (i_wen),
        .i_wdata  (i_wdata),
        .o_wready (o_wready),
        .i_ren    (i_ren),
        .o_rdata  (o_rdata),
        .o_rvalid (o_rvalid),
`ifdef COMMON_FIFO_D16_ERR_EN
        .o_count  (o_count),
        .o_err    (o_err)
`else
        .o_count  (o_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        n_chk   = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        i_wen   = 1'b0;
        i_ren   = 1'b0;
        i_wdata = 8'h00;
        #2;
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_rvalid", 32'(o_rvalid), 32'd0);
        check("rst_wready", 32'(o_wready), 32'd1);
`ifdef COMMON_FIFO_D16_ERR_EN
        check("rst_err", 32'(o_err), 32'd0);
`endif
        #1;
        resetn = 1'b1;

        // Single write on first active edge
        i_wen   = 1'b1;
        i_wdata = 8'h11;
        tick();
        i_wen = 1'b0;
        check("w1_rvalid", 32'(o_rvalid), 32'd1);
        check("w1_rdata", 32'(o_rdata), 32'h11);
        check("w1_count", 32'(o_count), 32'd1);
        i_ren = 1'b1;
        tick();
        i_ren = 1'b0;
        check("pop1_count", 32'(o_count), 32'd0);

        // Fill
        for (int i = 0; i < 16; i++) begin
            i_wen   = 1'b1;
            i_wdata = 8'(i);
            tick();
        end
        i_wen = 1'b0;
        check("full_count", 32'(o_count), 32'd16);
        check("full_wready", 32'(o_wready), 32'd0);
        check("full_rvalid", 32'(o_rvalid), 32'd1);

        // Full with write+read: only the read is taken
        i_wen   = 1'b1;
        i_ren   = 1'b1;
        i_wdata = 8'hAA;
        check("fullrw_head", 32'(o_rdata), 32'h00);
        tick();
        i_wen = 1'b0;
        check("fullrw_count", 32'(o_count), 32'd15);
        check("fullrw_wready", 32'(o_wready), 32'd1);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(o_rdata), 32'(i));
            tick();
        end
        i_ren = 1'b0;
        check("drain_count", 32'(o_count), 32'd0);
        check("drain_rvalid", 32'(o_rvalid), 32'd0);

        // Empty with write+read: only the write is taken
        i_wen   = 1'b1;
        i_ren   = 1'b1;
        i_wdata = 8'h55;
        tick();
        i_wen = 1'b0;
        i_ren = 1'b0;
        check("emptyrw_count", 32'(o_count), 32'd1);
        check("emptyrw_rdata", 32'(o_rdata), 32'h55);
        i_ren = 1'b1;
        tick();
        check("emptyrw_pop", 32'(o_count), 32'd0);

        // Read while empty is ignored
        tick();
        i_ren = 1'b0;
        check("uflow_count", 32'(o_count), 32'd0);
`ifdef COMMON_FIFO_D16_ERR_EN
        check("uflow_err", 32'(o_err), 32'd1);
`endif

        // Wrap at occupancy 3
        for (int i = 0; i < 3; i++) begin
            i_wen   = 1'b1;
            i_wdata = 8'h80 + 8'(i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            i_wen   = 1'b1;
            i_ren   = 1'b1;
            i_wdata = 8'h83 + 8'(k);
            v       = 8'h80 + 8'(k);
            check($sformatf("wrap_data_%0d", k), 32'(o_rdata), 32'(v));
            tick();
            check($sformatf("wrap_cnt_%0d", k), 32'(o_count), 32'd3);
        end
        i_ren = 1'b0;
        check("wrap_head", 32'(o_rdata), 32'hA8);
`ifdef COMMON_FIFO_D16_ERR_EN
        check("err_sticky", 32'(o_err), 32'd1);
`endif

        // Build up to 9 then reset asynchronously
        for (int i = 0; i < 6; i++) begin
            i_wen   = 1'b1;
            i_wdata = 8'hC0 + 8'(i);
            tick();
        end
        i_wen = 1'b0;
        check("pre_rst_count", 32'(o_count), 32'd9);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_rvalid", 32'(o_rvalid), 32'd0);
        check("arst_wready", 32'(o_wready), 32'd1);
`ifdef COMMON_FIFO_D16_ERR_EN
        check("arst_err", 32'(o_err), 32'd0);
`endif
        tick();
        resetn = 1'b1;
        i_wen   = 1'b1;
        i_wdata = 8'h3C;
        tick();
        i_wen = 1'b0;
        check("post_rst_count", 32'(o_count), 32'd1);
        check("post_rst_rdata", 32'(o_rdata), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
